display_timing_gen: RTL

Timing generator for the 640x480 @ 60 Hz VGA path. It divides the 100 MHz system clock into a 25 MHz pixel enable and runs the horizontal and vertical pixel counters. From those counters it drives `hSync`, `vSync`, `bright`, `hCount` and `vCount`: the raster interface consumed by every overlay/renderer (seats, background, sprites). It is the producing end of that interface and sits between the top level and all pixel-colour blocks.

---
 rtl/display_timing_gen_if.sv | 21 ++
 rtl/display_timing_gen.sv | 101 ++++++++++
 2 files changed

// File: rtl/display_timing_gen_if.sv
// Raster interface produced by display_timing_gen and consumed by the pixel-colour blocks.
// frame_count is present only when FRAME_COUNT_EN is defined.
`timescale 1ns/1ps
interface display_timing_gen_if;
    logic       pixel_tick;
    logic [9:0] hCount;
    logic [9:0] vCount;
    logic       hSync;
    logic       vSync;
    logic       bright;
    logic       frame_start;
`ifdef FRAME_COUNT_EN
    logic [7:0] frame_count;

    modport master (output pixel_tick, hCount, vCount, hSync, vSync, bright, frame_start, frame_count);
    modport slave  (input  pixel_tick, hCount, vCount, hSync, vSync, bright, frame_start, frame_count);
`else
    modport master (output pixel_tick, hCount, vCount, hSync, vSync, bright, frame_start);
    modport slave  (input  pixel_tick, hCount, vCount, hSync, vSync, bright, frame_start);
`endif
endinterface

// File: rtl/display_timing_gen.sv
// VGA timing generator: pixel-enable divider, h/v counters and registered sync/bright strobes.
// Optional frame counter enabled by defining FRAME_COUNT_EN.
`timescale 1ns/1ps
module display_timing_gen #(
    parameter int CLK_DIV      = 4,
    parameter int H_TOTAL      = 800,
    parameter int H_SYNC       = 96,
    parameter int H_DISP_START = 144,
    parameter int H_DISP_END   = 783,
    parameter int V_TOTAL      = 525,
    parameter int V_SYNC       = 2,
    parameter int V_DISP_START = 35,
    parameter int V_DISP_END   = 514
) (
    input  logic                 clk,
    input  logic                 rst,
    display_timing_gen_if.master vga
);
    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SW    = 10'(H_SYNC);
    localparam logic [9:0] V_SW    = 10'(V_SYNC);
    localparam logic [9:0] H_DS    = 10'(H_DISP_START);
    localparam logic [9:0] H_DE    = 10'(H_DISP_END);
    localparam logic [9:0] V_DS    = 10'(V_DISP_START);
    localparam logic [9:0] V_DE    = 10'(V_DISP_END);

    logic [DIV_W-1:0] div;
    logic [9:0]       h_count;
    logic [9:0]       v_count;
    logic [9:0]       h_next;
    logic [9:0]       v_next;
    logic             h_sync;
    logic             v_sync;
    logic             bright_q;
    logic             tick;
    logic             h_wrap;
    logic             v_wrap;

    function automatic logic in_window(input logic [9:0] h, input logic [9:0] v);
        return (h >= H_DS) && (h <= H_DE) && (v >= V_DS) && (v <= V_DE);
    endfunction

    assign tick   = (div == DIV_LAST);
    assign h_wrap = (h_count == H_LAST);
    assign v_wrap = (v_count == V_LAST);

    always_comb begin
        h_next = h_count;
        v_next = v_count;
        if (tick) begin
            h_next = h_wrap ? 10'd0 : h_count + 10'd1;
            if (h_wrap) begin
                v_next = v_wrap ? 10'd0 : v_count + 10'd1;
            end
        end
    end

    // Strobes are loaded from the next counter values so they never lag the counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            div      <= '0;
            h_count  <= '0;
            v_count  <= '0;
            h_sync   <= 1'b0;
            v_sync   <= 1'b0;
            bright_q <= 1'b0;
        end else begin
            div      <= tick ? '0 : div + DIV_W'(1);
            h_count  <= h_next;
            v_count  <= v_next;
            h_sync   <= (h_next >= H_SW);
            v_sync   <= (v_next >= V_SW);
            bright_q <= in_window(h_next, v_next);
        end
    end

    assign vga.pixel_tick  = tick;
    assign vga.hCount      = h_count;
    assign vga.vCount      = v_count;
    assign vga.hSync       = h_sync;
    assign vga.vSync       = v_sync;
    assign vga.bright      = bright_q;
    assign vga.frame_start = tick && h_wrap && v_wrap;

`ifdef FRAME_COUNT_EN
    logic [7:0] frame_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= 8'd0;
        end else if (vga.frame_start) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    assign vga.frame_count = frame_cnt;
`endif
endmodule
